// File: rtl/booth_multiplier_seq_32.sv
// ----------------------------------------------------------------------------
// booth_multiplier_seq_32
//   Sequential signed 32x32 -> 64 radix-4 (bit-pair) Booth multiplier for the
//   Mini-SRC MUL path. One bit-pair is retired per clock, so a full operation
//   takes 16 RUN cycles. Each cycle adds one of {0, +-M, +-2M} shifted by 2k.
//
// Ports
//   in_clk           in   1   system clock, rising edge
//   in_clr           in   1   asynchronous active-high reset
//   in_start         in   1   start request (accepted in IDLE, or on the DONE exit edge)
//   in_multiplicand  in  32   M, signed, captured on the accepted start
//   in_multiplier    in  32   Q, signed, captured on the accepted start
//   out_busy         out  1   high in RUN and DONE
//   out_done         out  1   one-cycle pulse, product valid
//   out_product      out 64   signed product {HI,LO}, held until the next result
//
// Configuration
//   EARLY_TERM_EN : when defined, RUN ends as soon as the unprocessed upper
//                   multiplier bits are all-0s or all-1s (they would only
//                   recode to zero digits). The product is identical.
// ----------------------------------------------------------------------------
module booth_multiplier_seq_32 (
    input  logic        in_clk,
    input  logic        in_clr,
    input  logic        in_start,
    input  logic [31:0] in_multiplicand,
    input  logic [31:0] in_multiplier,
    output logic        out_busy,
    output logic        out_done,
    output logic [63:0] out_product
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]  state;
    logic [63:0] m_ext;     // multiplicand sign-extended to full product width
    logic [31:0] q;
    logic [63:0] acc;
    logic [3:0]  k;         // bit-pair index

    logic [32:0] q_ext;     // {Q, Q[-1]=0}
    logic [2:0]  pair;
    logic [63:0] m_dbl;
    logic [63:0] pp;
    logic [63:0] acc_next;
    logic        last;

    // ------------------------------------------------------------------------
    // Booth recoding and accumulate. +-M and +-2M are built at 64 bits so that
    // 2M never loses its top bit (needed for |M| >= 2^30, M = -2^31).
    // ------------------------------------------------------------------------
    always_comb begin
        q_ext = {q, 1'b0};
        pair  = q_ext[{k, 1'b0} +: 3];
        m_dbl = m_ext << 1;
        pp    = '0;
        case (pair)
            3'b000, 3'b111: pp = '0;
            3'b001, 3'b010: pp = m_ext;
            3'b011:         pp = m_dbl;
            3'b100:         pp = ~m_dbl + 64'd1;
            3'b101, 3'b110: pp = ~m_ext + 64'd1;
            default:        pp = '0;
        endcase
        acc_next = acc + (pp << {k, 1'b0});
    end

`ifdef EARLY_TERM_EN
    logic signed [31:0] q_rem;

    // After pair k, bits Q[31:2k+1] remain; shifting them down arithmetically
    // gives all-0s or all-1s exactly when every remaining digit recodes to 0.
    always_comb begin
        q_rem = $signed(q) >>> {k, 1'b1};
        last  = (q_rem == '0) || (q_rem == '1) || (k == 4'd15);
    end
`else
    always_comb begin
        last = (k == 4'd15);
    end
`endif

    // ------------------------------------------------------------------------
    // Control FSM and datapath registers
    // ------------------------------------------------------------------------
    always_ff @(posedge in_clk or posedge in_clr) begin
        if (in_clr) begin
            state       <= S_IDLE;
            m_ext       <= '0;
            q           <= '0;
            acc         <= '0;
            k           <= '0;
            out_done    <= 1'b0;
            out_product <= '0;
        end else begin
            out_done <= (state == S_DONE);
            case (state)
                S_IDLE, S_DONE: begin
                    if (in_start) begin
                        m_ext <= {{32{in_multiplicand[31]}}, in_multiplicand};
                        q     <= in_multiplier;
                        acc   <= '0;
                        k     <= '0;
                        state <= S_RUN;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    acc <= acc_next;
                    k   <= k + 4'd1;
                    if (last) begin
                        // Product register updates on the DONE entry edge only;
                        // out_done follows on the edge that leaves DONE.
                        out_product <= acc_next;
                        state       <= S_DONE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign out_busy = (state == S_RUN) || (state == S_DONE);

endmodule
